// File: rtl/change_dispenser_if.sv
// Request, hopper and status signals of the change dispenser.
// The slave modport is the dispenser; the master modport is the calculator/hopper side.
interface change_dispenser_if;
  logic [2:0] quarter_req;
  logic       dollar_req;
  logic       coin_sensed;
  logic       d_eject;
  logic       q_eject;
  logic       busy;
  logic       done;
  logic       jam;
  logic       overrun;
  logic [2:0] quarters_paid;
  logic       dollars_paid;
  logic [2:0] state_dbg;

  // Handshake: quarter_req/dollar_req are a one-cycle strobe with no ready;
  // they are taken only while busy is low, otherwise dropped and flagged by overrun.
  modport master (
    output quarter_req, dollar_req, coin_sensed,
    input  d_eject, q_eject, busy, done, jam, overrun,
    input  quarters_paid, dollars_paid, state_dbg
  );

  modport slave (
    input  quarter_req, dollar_req, coin_sensed,
    output d_eject, q_eject, busy, done, jam, overrun,
    output quarters_paid, dollars_paid, state_dbg
  );
endinterface

// File: rtl/change_dispenser.sv
// Captures a change request and ejects the coins one by one, confirming each on the exit sensor.
// Optional jam timeout built when DISPENSE_TIMEOUT_EN is defined.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  change_dispenser_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EJECT      = 3'd1,
    WAIT_SENSE = 3'd2,
    GAP        = 3'd3,
    DONE       = 3'd4
`ifdef DISPENSE_TIMEOUT_EN
    , JAM      = 3'd5
`endif
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic        sensed_q;
  logic [2:0]  q_left;
  logic        d_left;
  logic [2:0]  quarters_paid_q;
  logic        dollars_paid_q;
  logic        overrun_q;
  logic        req_nz;
  logic        capture;
  logic        credit;

  assign req_nz = (bus.quarter_req != 3'd0) || bus.dollar_req;

`ifdef DISPENSE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt;
  logic        timeout_hit;
  assign timeout_hit = (tcnt == TIMEOUT_LAST);
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_n = state;
    capture = 1'b0;
    credit  = 1'b0;
    case (state)
      IDLE: begin
        if (req_nz) begin
          capture = 1'b1;
          state_n = EJECT;
        end
      end
      EJECT: begin
        // A sense in the last pulse cycle still counts for this coin.
        if (cnt == PULSE_LAST) begin
          if (sensed_q || bus.coin_sensed) begin
            credit  = 1'b1;
            state_n = GAP;
          end else begin
            state_n = WAIT_SENSE;
          end
        end
      end
      WAIT_SENSE: begin
        if (bus.coin_sensed) begin
          credit  = 1'b1;
          state_n = GAP;
        end
`ifdef DISPENSE_TIMEOUT_EN
        else if (timeout_hit) begin
          state_n = JAM;
        end
`endif
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ((q_left != 3'd0) || d_left) ? EJECT : DONE;
        end
      end
      DONE: state_n = IDLE;
`ifdef DISPENSE_TIMEOUT_EN
      JAM:  state_n = JAM;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sensed_q        <= 1'b0;
      q_left          <= '0;
      d_left          <= 1'b0;
      quarters_paid_q <= '0;
      dollars_paid_q  <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? 16'd0 : cnt + 16'd1;
      // Sense latch lives only inside one EJECT episode.
      sensed_q <= (state == EJECT && state_n == EJECT) ? (sensed_q | bus.coin_sensed) : 1'b0;
      if (state != IDLE && req_nz) begin
        overrun_q <= 1'b1;
      end
      if (capture) begin
        q_left          <= bus.quarter_req;
        d_left          <= bus.dollar_req;
        quarters_paid_q <= '0;
        dollars_paid_q  <= 1'b0;
      end else if (credit) begin
        if (d_left) begin
          d_left         <= 1'b0;
          dollars_paid_q <= 1'b1;
        end else begin
          q_left          <= q_left - 3'd1;
          quarters_paid_q <= quarters_paid_q + 3'd1;
        end
      end
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state_n == EJECT && state != EJECT) begin
      tcnt <= '0;
    end else if (state == EJECT || state == WAIT_SENSE) begin
      tcnt <= tcnt + 16'd1;
    end
  end
  assign bus.jam = (state == JAM);
`else
  assign bus.jam = 1'b0;
`endif

  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.d_eject       = (state == EJECT) && d_left;
  assign bus.q_eject       = (state == EJECT) && !d_left;
  assign bus.overrun       = overrun_q;
  assign bus.quarters_paid = quarters_paid_q;
  assign bus.dollars_paid  = dollars_paid_q;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: hopper model, timing reference model and a done/coin scoreboard.
module tb_change_dispenser;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  change_dispenser_if bus();
  logic hop_sense = 1'b0;
  logic idle_pulse = 1'b0;
  assign bus.coin_sensed = hop_sense | idle_pulse;

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic        coin_q[$];
  int          hop_q[$];
  int          rise_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected coins on each eject rise and expected results on done.
  logic        prev_ej = 1'b0;
  logic        ej;
  int          width = 0;
  logic        exp_coin;
  logic [31:0] rec;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_ej = 1'b0;
      width = 0;
    end else begin
      ej = bus.d_eject | bus.q_eject;
      if (bus.d_eject && bus.q_eject) check("both_ejects", 1, 0);
      if (ej && !prev_ej) begin
        rise_cnt++;
        width = 0;
        if (coin_q.size() == 0) check("unexpected_eject", 1, 0);
        else begin
          exp_coin = coin_q.pop_front();
          check("coin_is_dollar", int'(bus.d_eject), int'(exp_coin));
        end
      end
      if (ej) width++;
      else if (prev_ej) check("eject_width", width, P);
      if (bus.done) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          rec = exp_q.pop_front();
          check("done_cycle", cyc, int'(rec[31:4]));
          check("dollars_paid", int'(bus.dollars_paid), int'(rec[3]));
          check("quarters_paid", int'(bus.quarters_paid), int'(rec[2:0]));
        end
      end
      prev_ej = ej;
    end
  end

  // Hopper: each eject rise takes one behaviour entry {double, width, delay}; negative = never senses.
  logic hop_prev = 1'b0;
  int   sense_at = -100;
  int   s_w = 1;
  logic s_dbl = 1'b0;
  int   h;
  always @(negedge clk) begin
    if ((bus.d_eject | bus.q_eject) && !hop_prev) begin
      if (hop_q.size() > 0) begin
        h = hop_q.pop_front();
        if (h < 0) sense_at = -100;
        else begin
          sense_at = cyc + (h % 16);
          s_w = (h / 16) % 16;
          s_dbl = (h / 256) != 0;
        end
      end else sense_at = -100;
    end
    hop_prev = bus.d_eject | bus.q_eject;
    hop_sense = (cyc >= sense_at && cyc < sense_at + s_w) || (s_dbl && cyc == sense_at + s_w + 1);
  end

  // Driver with reference model: done lands one cycle after the sum of per-coin periods,
  // each period being max(pulse, sense delay + 1) plus the gap.
  task automatic issue(input int q, input int d, input bit accept, input int delay, input bit dbl);
    int t;
    int s;
    int w;
    int hh;
    @(negedge clk);
    bus.quarter_req = q[2:0];
    bus.dollar_req = d[0];
    if (accept && (q != 0 || d != 0)) begin
      t = cyc + 1;
      for (int i = 0; i < d + q; i++) begin
        if (delay >= 0) begin
          s = delay;
          w = 1;
          hh = s + 16 * w + (dbl ? 256 : 0);
        end else begin
          s = $urandom_range(0, 7);
          w = $urandom_range(1, 2);
          hh = s + 16 * w + ((w == 1 && $urandom_range(0, 1) == 1) ? 256 : 0);
        end
        hop_q.push_back(hh);
        coin_q.push_back(i < d);
        t += ((s + 1 > P) ? s + 1 : P) + G;
      end
      exp_q.push_back({t[27:0], d[0], q[2:0]});
    end
    @(negedge clk);
    bus.quarter_req = 3'd0;
    bus.dollar_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_jam"}, int'(bus.jam), 0);
    check({tag, "_overrun"}, int'(bus.overrun), 0);
    check({tag, "_d_eject"}, int'(bus.d_eject), 0);
    check({tag, "_q_eject"}, int'(bus.q_eject), 0);
    check({tag, "_quarters_paid"}, int'(bus.quarters_paid), 0);
    check({tag, "_dollars_paid"}, int'(bus.dollars_paid), 0);
    check({tag, "_state_idle"}, int'(bus.state_dbg), 0);
  endtask

  task automatic do_reset();
    exp_q.delete();
    coin_q.delete();
    hop_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  int base;
  int q;
  int d;
  int cap;

  initial begin
    bus.quarter_req = 3'd0;
    bus.dollar_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // Three quarters, sensed 2 cycles into each pulse.
    issue(3, 0, 1'b1, 2, 1'b0);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("paid_hold", int'(bus.quarters_paid), 3);

    // Dollar then quarter.
    issue(1, 1, 1'b1, 1, 1'b0);
    wait_idle(200);

    // Overrun during a 4-quarter transaction.
    issue(4, 0, 1'b1, -1, 1'b0);
    repeat (5) @(negedge clk);
    issue(2, 0, 1'b0, 0, 1'b0);
    wait_idle(300);
    check("overrun_set", int'(bus.overrun), 1);
    check("overrun_paid", int'(bus.quarters_paid), 4);

    // Reset during the second quarter's pulse.
    base = rise_cnt;
    issue(3, 0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 100 && rise_cnt < base + 2; i++) @(negedge clk);
    check("second_rise_seen", int'(rise_cnt >= base + 2), 1);
    do_reset();
    repeat (3) @(negedge clk);
    issue(1, 0, 1'b1, 3, 1'b0);
    wait_idle(200);
    check("after_reset_paid", int'(bus.quarters_paid), 1);

    // Sensor pulse in IDLE is ignored; double pulse credits one coin.
    @(negedge clk);
    idle_pulse = 1'b1;
    @(negedge clk);
    idle_pulse = 1'b0;
    @(posedge clk);
    #1;
    check("idle_pulse_busy", int'(bus.busy), 0);
    issue(1, 0, 1'b1, 0, 1'b1);
    wait_idle(200);
    check("double_pulse_paid", int'(bus.quarters_paid), 1);

    // Random transactions.
    for (int n = 0; n < 25; n++) begin
      q = $urandom_range(0, 7);
      d = $urandom_range(0, 1);
      issue(q, d, 1'b1, -1, 1'b0);
      if (q == 0 && d == 0) begin
        @(posedge clk);
        #1;
        check("zero_req_busy", int'(bus.busy), 0);
      end
      wait_idle(400);
    end

`ifdef DISPENSE_TIMEOUT_EN
    // No sensor response: jam after the timeout.
    @(negedge clk);
    hop_q.push_back(-1);
    coin_q.push_back(1'b0);
    bus.quarter_req = 3'd2;
    cap = cyc;
    @(negedge clk);
    bus.quarter_req = 3'd0;
    while (cyc < cap + T) begin
      @(posedge clk);
      #1;
    end
    check("jam_before", int'(bus.jam), 0);
    @(posedge clk);
    #1;
    check("jam_rise", int'(bus.jam), 1);
    repeat (10) @(posedge clk);
    #1;
    check("jam_sticky", int'(bus.jam), 1);
    check("jam_busy", int'(bus.busy), 1);
    check("jam_q_eject", int'(bus.q_eject), 0);
    check("jam_d_eject", int'(bus.d_eject), 0);
    @(negedge clk);
    do_reset();
`else
    check("jam_tied", int'(bus.jam), 0);
`endif

    check("coin_q_empty", coin_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending-machine change calculator. Captures the one-cycle change request (quarter count and dollar flag) the calculator produces, then drives the coin-hopper eject solenoids one coin at a time. Each coin is confirmed by the hopper's exit sensor, with optional jam detection. Reports busy, completion and coins actually paid.

## Interface

Parameters:
- PULSE_CYCLES, 4: eject pulse width in clocks (≥1).
- GAP_CYCLES, 2: idle clocks between consecutive coins (≥1).
- TIMEOUT_CYCLES, 1000: per-coin sense timeout in clocks (16-bit, ≥PULSE_CYCLES+1). Only used when DISPENSE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- quarter_req  in  3  quarters to return, binary 0..7, valid one cycle.
- dollar_req  in  1  one dollar coin to return, valid same cycle.
- coin_sensed  in  1  hopper exit sensor, synchronous, ≥1-cycle pulse per coin.
- d_eject  out  1  dollar solenoid drive.
- q_eject  out  1  quarter solenoid drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all requested coins are confirmed.
- jam  out  1  sticky; a coin was not sensed within the timeout.
- overrun  out  1  sticky; a nonzero request arrived while busy.
- quarters_paid  out  3  quarters confirmed this transaction.
- dollars_paid  out  1  dollar confirmed this transaction.

## Operation

- Reset: state IDLE. All outputs 0, internal remaining counts 0. Any in-flight transaction is discarded.
- IDLE: a request is nonzero when quarter_req≠0 or dollar_req=1. On a nonzero request:
  - Latch q_left=quarter_req and d_left=dollar_req.
  - Clear quarters_paid and dollars_paid.
  - Go to EJECT.
  - A zero request does nothing.
- Coin order: the dollar is dispensed first, then the quarters.
- EJECT: drive d_eject if d_left=1, else q_eject, for exactly PULSE_CYCLES cycles. A coin_sensed seen during EJECT is latched. At the end of the pulse:
  - If sensed: go to GAP.
  - Otherwise: go to WAIT_SENSE.
- WAIT_SENSE: both ejects low. On coin_sensed go to GAP.
- On confirmation, in the cycle of entry to GAP:
  - Dollar: d_left←0, dollars_paid←1.
  - Quarter: q_left−1, quarters_paid+1.
- GAP: hold for GAP_CYCLES cycles.
  - If coins remain: go to EJECT.
  - Otherwise: go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. Paid counts hold until the next capture.
- JAM: both ejects low, jam=1, busy=1. Stays until reset.
- coin_sensed is ignored in IDLE, GAP, DONE and JAM. Only one coin is credited per EJECT/WAIT_SENSE episode, even if the sensor pulses more than once.
- A nonzero request while busy is dropped and sets overrun. The transaction in progress is unaffected.
- The quarter count saturates at 7 by construction. No arithmetic wrap is possible.

## Timing

- Request sampled at edge n: busy=1 and the selected eject=1 from cycle n+1.
- Eject high for cycles n+1..n+PULSE_CYCLES.
- With the sense inside the pulse, per-coin period = PULSE_CYCLES+GAP_CYCLES.
- Sense in WAIT_SENSE at cycle m: GAP is entered at m+1, and the next eject (or done) at m+1+GAP_CYCLES.
- Total for k coins, each sensed within its pulse: done high at cycle n+k·(PULSE_CYCLES+GAP_CYCLES)+1, IDLE at the following cycle.
- A new request can be accepted in the first IDLE cycle after done.
- Timeout counter:
  - Cleared on EJECT entry; increments in EJECT and WAIT_SENSE.
  - If it reaches TIMEOUT_CYCLES−1 with no sense, the next state is JAM.
  - jam rises TIMEOUT_CYCLES cycles after the eject rise.

## Configuration

- DISPENSE_TIMEOUT_EN defined: the timeout counter and the JAM state are built, with behaviour as above.
- DISPENSE_TIMEOUT_EN undefined: no counter and no JAM state. WAIT_SENSE waits indefinitely, jam is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan

All scenarios use default parameters, with TIMEOUT_CYCLES=20 and DISPENSE_TIMEOUT_EN defined.

- quarter_req=3 for one cycle; coin_sensed 2 cycles after each q_eject rise:
  - Three 4-cycle q_eject pulses, 6 cycles apart, no d_eject.
  - done pulse at capture+19; quarters_paid=3, dollars_paid=0.
- dollar_req=1 with quarter_req=1, sensor echoing each pulse:
  - d_eject pulse precedes q_eject.
  - dollars_paid=1, quarters_paid=1, single done pulse.
- quarter_req=2, coin_sensed never asserted:
  - q_eject high 4 cycles.
  - jam=1 at eject rise+20; busy stays 1, ejects stay 0 until reset.
- quarter_req=4, then quarter_req=2 mid-transaction:
  - overrun=1; exactly 4 coins dispensed; quarters_paid=4.
- reset asserted during the second quarter's eject pulse:
  - All outputs 0 the next cycle.
  - A subsequent quarter_req=1 completes normally with quarters_paid=1.
- coin_sensed pulsed in IDLE, then a quarter_req=1 with a double sensor pulse:
  - Idle pulse ignored; quarters_paid=1, not 2.
